// File: rtl/dp_sqrt_pkg.sv
// Shared types and constants for the binary64 square-root round/pack stage.
package dp_sqrt_pkg;

   localparam int unsigned EXP_W  = 11;
   localparam int unsigned FRAC_W = 52;
   localparam int unsigned ROOT_W = 54;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned CLS_W  = 3;

   localparam logic [DATA_W-1:0] QNAN64 = 64'h7FF8_0000_0000_0000;
   localparam logic [DATA_W-1:0] PINF64 = 64'h7FF0_0000_0000_0000;

   // Operand class reported by the upstream square-root core.
   typedef enum logic [CLS_W-1:0] {
      NORMAL      = 3'd0,
      ZERO        = 3'd1,
      INF         = 3'd2,
      NAN         = 3'd3,
      NEG_INVALID = 3'd4
   } dp_class_e;

   // Stage-1 payload: class, sign, exponent, rounded fraction and the
   // round-up carry that still has to be folded into the exponent.
   typedef struct packed {
      dp_class_e         cls;
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
      logic              carry;
   } s1_payload_t;

endpackage

// File: rtl/dp_round_rne.sv
// Round-to-nearest-even increment of a 52-bit fraction with carry-out.
module dp_round_rne
   import dp_sqrt_pkg::*;
(
   input  logic [FRAC_W-1:0] frac,
   input  logic              round_bit,
   input  logic              sticky,
   output logic [FRAC_W-1:0] frac_rnd,
   output logic              carry
);

   logic inc;

   // Round up above half, or exactly at half when the fraction is odd.
   assign inc = round_bit && (sticky || frac[0]);
   assign {carry, frac_rnd} = {1'b0, frac} + (FRAC_W+1)'(inc);

endmodule

// File: rtl/dp_sqrt_round_pack.sv
// Two-stage round and pack of a square-root result into IEEE-754 binary64.
// Optional DP_SQRT_FLAGS_EN adds out_flags = {invalid, inexact}.
module dp_sqrt_round_pack
   import dp_sqrt_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CLS_W-1:0]  in_class,
   input  logic              in_sign,
   input  logic [EXP_W-1:0]  in_exp,
   input  logic [ROOT_W-1:0] in_root,
   input  logic              in_sticky,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
`ifdef DP_SQRT_FLAGS_EN
   ,
   output logic [1:0]        out_flags
`endif
);

   logic              run_en;
   logic              s1_valid;
   s1_payload_t       s1_q;
   s1_payload_t       s1_d;
   logic              s2_adv;
   logic              s1_adv;
   logic              in_fire;
   logic [FRAC_W-1:0] frac_rnd;
   logic              frac_carry;
   logic [EXP_W:0]    exp_sum;
   logic [DATA_W-1:0] pack;
   logic              unused_hidden;

   // The hidden bit is implied by the NORMAL class and carries no information.
   assign unused_hidden = in_root[ROOT_W-1];

   dp_round_rne u_round (
      .frac      (in_root[ROOT_W-2:1]),
      .round_bit (in_root[0]),
      .sticky    (in_sticky),
      .frac_rnd  (frac_rnd),
      .carry     (frac_carry)
   );

   // Handshake: stage 2 takes data when empty or draining; stage 1 follows.
   always_comb begin
      s2_adv   = !out_valid || out_ready;
      s1_adv   = s1_valid && s2_adv;
      in_ready = run_en && (!s1_valid || s1_adv);
      in_fire  = in_valid && in_ready;
   end

   // Stage-1 payload from the incoming result.
   always_comb begin
      s1_d       = '0;
      s1_d.cls   = dp_class_e'(in_class);
      s1_d.sign  = in_sign;
      s1_d.exp   = in_exp;
      s1_d.frac  = frac_rnd;
      s1_d.carry = frac_carry;
   end

   // Pack the stage-1 payload into a binary64 word.
   always_comb begin
      pack    = QNAN64;
      exp_sum = {1'b0, s1_q.exp} + (EXP_W+1)'(s1_q.carry);
      case (s1_q.cls)
         NORMAL: begin
            if (exp_sum >= (EXP_W+1)'(12'h7FF)) begin
               pack = PINF64;
            end else begin
               pack = {1'b0, exp_sum[EXP_W-1:0], s1_q.frac};
            end
         end
         ZERO:    pack = {s1_q.sign, 63'b0};
         INF:     pack = PINF64;
         default: pack = QNAN64;
      endcase
   end

   // Pipeline registers for both stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_en    <= 1'b0;
         s1_valid  <= 1'b0;
         s1_q      <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         run_en <= 1'b1;
         if (in_fire) begin
            s1_valid <= 1'b1;
            s1_q     <= s1_d;
         end else if (s1_adv) begin
            s1_valid <= 1'b0;
         end
         if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_data <= pack;
            end
         end
      end
   end

`ifdef DP_SQRT_FLAGS_EN
   logic [1:0] s1_flags;
   logic [1:0] flags_d;

   // Flags: invalid for negative operands, inexact for any discarded bits.
   always_comb begin
      flags_d    = 2'b00;
      flags_d[1] = (dp_class_e'(in_class) == NEG_INVALID);
      flags_d[0] = (dp_class_e'(in_class) == NORMAL) && (in_root[0] || in_sticky);
   end

   // Flag registers travel with the data through both stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_flags  <= 2'b00;
         out_flags <= 2'b00;
      end else begin
         if (in_fire) begin
            s1_flags <= flags_d;
         end
         if (s2_adv && s1_valid) begin
            out_flags <= s1_flags;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dp_sqrt_round_pack.sv
// Self-checking bench for dp_sqrt_round_pack (DP_SQRT_FLAGS_EN optional).
module tb_dp_sqrt_round_pack;
   import dp_sqrt_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_class;
   logic        in_sign;
   logic [10:0] in_exp;
   logic [53:0] in_root;
   logic        in_sticky;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
`ifdef DP_SQRT_FLAGS_EN
   logic [1:0]  out_flags;
`endif

   typedef struct packed {
      logic [63:0] d;
      logic [1:0]  f;
   } exp_t;

   typedef struct packed {
      logic [2:0]  cls;
      logic        sign;
      logic [10:0] exp;
      logic [53:0] root;
      logic        sticky;
   } item_t;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   dp_sqrt_round_pack dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_class  (in_class),
      .in_sign   (in_sign),
      .in_exp    (in_exp),
      .in_root   (in_root),
      .in_sticky (in_sticky),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef DP_SQRT_FLAGS_EN
      ,
      .out_flags (out_flags)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference: value = root/2 with root[0] as half-ulp, sticky below it.
   function automatic exp_t model(input item_t it);
      exp_t        r;
      logic [53:0] m;
      int          e;
      logic        half;
      logic        odd;
      r.f = {it.cls == 3'(NEG_INVALID),
             (it.cls == 3'(NORMAL)) && (it.root[0] || it.sticky)};
      case (it.cls)
         3'(NORMAL): begin
            m    = {1'b0, it.root[53:1]};
            half = it.root[0];
            odd  = m[0];
            if (half && (it.sticky || odd)) m = m + 54'd1;
            e = int'(it.exp);
            if (m == (54'd1 << 53)) begin
               e = e + 1;
               m = m >> 1;
            end
            if (e >= 2047) r.d = 64'h7FF0_0000_0000_0000;
            else           r.d = {1'b0, 11'(e), m[51:0]};
         end
         3'(ZERO): r.d = {it.sign, 63'b0};
         3'(INF):  r.d = 64'h7FF0_0000_0000_0000;
         default:  r.d = 64'h7FF8_0000_0000_0000;
      endcase
      return r;
   endfunction

   function automatic item_t rand_item();
      item_t it;
      int    c;
      c = int'($urandom_range(0, 9));
      if (c <= 5)      it.cls = 3'(NORMAL);
      else if (c == 6) it.cls = 3'(ZERO);
      else if (c == 7) it.cls = 3'(INF);
      else if (c == 8) it.cls = 3'(NAN);
      else             it.cls = 3'(NEG_INVALID);
      it.sign   = 1'($urandom);
      it.exp    = 11'($urandom_range(1, 2046));
      it.root   = {1'b1, 21'($urandom), 32'($urandom)};
      it.sticky = 1'($urandom);
      if ($urandom_range(0, 7) == 0) it.root = {54{1'b1}};
      if ($urandom_range(0, 7) == 0) it.exp = 11'h7FE;
      return it;
   endfunction

   task automatic drive(input logic v, input item_t it);
      in_valid  = v;
      in_class  = it.cls;
      in_sign   = it.sign;
      in_exp    = it.exp;
      in_root   = it.root;
      in_sticky = it.sticky;
   endtask

   function automatic item_t mk(input logic [2:0] c, input logic s, input logic [10:0] e,
                                input logic [53:0] r, input logic st);
      item_t it;
      it.cls = c; it.sign = s; it.exp = e; it.root = r; it.sticky = st;
      return it;
   endfunction

   // Offer one item and hold it until accepted; returns just after the transfer edge.
   task automatic send(input item_t it);
      int n = 0;
      @(posedge clk); #1;
      drive(1'b1, it);
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("send_accept", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Single result through an idle pipe: absent after one edge, present after two.
   task automatic send_check(input string tag, input item_t it, input logic [63:0] k);
      send(it);
      @(negedge clk);
      chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk(tag, out_data, k);
   endtask

   // Scoreboard: record accepted inputs, compare emerging results, watch stalls.
   logic        hold_chk = 1'b0;
   logic [63:0] hold_data;
   exp_t        got;
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_chk = 1'b0;
      end else begin
         if (hold_chk) begin
            chk("stall_hold_data", out_data, hold_data);
            chk("stall_hold_valid", 64'(out_valid), 64'd1);
         end
         if (out_valid && out_ready) begin
            chk("result_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               got = exp_q.pop_front();
               chk("result_data", out_data, got.d);
`ifdef DP_SQRT_FLAGS_EN
               chk("result_flags", 64'(out_flags), 64'(got.f));
`endif
            end
         end
         if (in_valid && in_ready)
            exp_q.push_back(model(mk(in_class, in_sign, in_exp, in_root, in_sticky)));
         hold_chk  = out_valid && !out_ready;
         hold_data = out_data;
      end
   end

   item_t       bp[3];
   int          k;
   logic        have;
   logic [63:0] held;
   int          n;

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, mk(3'd0, 1'b0, 11'd0, 54'd0, 1'b0));

      // Reset state, independent of clock edges.
      #3;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready_clk", 64'(in_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_in_ready_pre", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      chk("rel_in_ready_post", 64'(in_ready), 64'd1);

      // Directed values.
      send_check("one", mk(3'(NORMAL), 1'b0, 11'h3FF, 54'h20_0000_0000_0000, 1'b0),
                 64'h3FF0_0000_0000_0000);
      send_check("tie_up", mk(3'(NORMAL), 1'b0, 11'h3FF, 54'h20_0000_0000_0003, 1'b0),
                 64'h3FF0_0000_0000_0002);
      send_check("tie_even", mk(3'(NORMAL), 1'b0, 11'h3FF, 54'h20_0000_0000_0001, 1'b0),
                 64'h3FF0_0000_0000_0000);
      send_check("carry", mk(3'(NORMAL), 1'b0, 11'h3FF, 54'h3F_FFFF_FFFF_FFFF, 1'b1),
                 64'h4000_0000_0000_0000);
      send_check("carry_inf", mk(3'(NORMAL), 1'b0, 11'h7FE, 54'h3F_FFFF_FFFF_FFFF, 1'b0),
                 64'h7FF0_0000_0000_0000);
      send_check("neg_invalid", mk(3'(NEG_INVALID), 1'b1, 11'h123, 54'h25_5555_0000_1111, 1'b1),
                 64'h7FF8_0000_0000_0000);
`ifdef DP_SQRT_FLAGS_EN
      chk("neg_invalid_flags", 64'(out_flags), 64'd2);
`endif
      send_check("neg_zero", mk(3'(ZERO), 1'b1, 11'h000, 54'd0, 1'b0),
                 64'h8000_0000_0000_0000);
      send_check("pos_zero", mk(3'(ZERO), 1'b0, 11'h000, 54'd0, 1'b0), 64'h0);
      send_check("inf", mk(3'(INF), 1'b1, 11'h7FF, 54'd0, 1'b0), 64'h7FF0_0000_0000_0000);
      send_check("nan", mk(3'(NAN), 1'b0, 11'h7FF, 54'h3F_0000_0000_0000, 1'b1),
                 64'h7FF8_0000_0000_0000);

      // Backpressure: three items offered while the output is blocked.
      for (int i = 0; i < 3; i++) begin
         bp[i] = rand_item();
         bp[i].cls = 3'(NORMAL);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
      k    = 0;
      have = 1'b0;
      held = '0;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         if (k < 3) drive(1'b1, bp[k]);
         else       in_valid = 1'b0;
         @(negedge clk);
         if (in_valid && in_ready) k++;
         if (out_valid && !have) begin
            have = 1'b1;
            held = out_data;
         end
      end
      chk("bp_accepts", 64'(k), 64'd2);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_held_data", out_data, held);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      drive(1'b1, bp[2]);
      @(negedge clk);
      chk("bp_rel_accept", 64'(in_ready), 64'd1);
      chk("bp_rel_out0", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp_rel_out1", 64'(out_valid), 64'd1);
      @(negedge clk);
      chk("bp_rel_out2", 64'(out_valid), 64'd1);
      @(negedge clk);
      chk("bp_rel_empty", 64'(out_valid), 64'd0);

      // Reset with two results in flight.
      out_ready = 1'b0;
      send(rand_item());
      send(rand_item());
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd0);
      chk("midrst_out_data", out_data, 64'd0);
      exp_q.delete();
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("midrst_no_stale", 64'(out_valid), 64'd0);
      end

      // Random traffic with random backpressure.
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         out_ready = ($urandom_range(0, 3) != 0);
         drive($urandom_range(0, 3) != 0, rand_item());
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      chk("drain_idle", 64'(out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dp_sqrt_round_pack.md
DP_SQRT_ROUND_PACK -- requirements
Module: dp_sqrt_round_pack

Interface
REQ-001 SHALL have ports `clk`, `rst_n`, `in_valid`, `in_ready`, `in_class`, `in_sign`, `in_exp`, `in_root`, `in_sticky`, `out_valid`, `out_ready`, `out_data`.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream square-root core presents a result.
REQ-005 in_ready  output  1  block accepts the input this cycle.
REQ-006 in_class  input  3  operand class: NORMAL, ZERO, INF, NAN, NEG_INVALID.
REQ-007 in_sign  input  1  operand sign; used only for ZERO.
REQ-008 in_exp  input  11  biased result exponent, already halved and rebiased.
REQ-009 in_root  input  54  root significand: bit53 hidden 1, bits52:1 fraction, bit0 round bit.
REQ-010 in_sticky  input  1  final remainder non-zero.
REQ-011 out_valid  output  1  packed result available.
REQ-012 out_ready  input  1  downstream accepts.
REQ-013 out_data  output  64  IEEE-754 binary64 result.

Function
REQ-014 Transfers occur on valid&&ready at the rising clock edge, on both ports.
REQ-015 The block SHALL be two register stages. Stage 1 registers the class, sign, exponent, fraction and the round-up decision. Stage 2 registers the packed word.
REQ-016 Latency SHALL be 2 cycles from input transfer to out_valid when out_ready stays high; throughput SHALL be 1 result per cycle.
REQ-017 Rounding SHALL be RNE: increment = in_root[0] && (in_sticky || in_root[1]).
REQ-018 A fraction carry-out SHALL zero the fraction and add 1 to the exponent. If the exponent reaches 11'h7FF, the result SHALL be +Inf.
REQ-019 Class NORMAL SHALL produce {1'b0, exp, fraction}. The sign SHALL always be 0.
REQ-020 Class ZERO SHALL produce {in_sign, 63'b0}; sqrt(-0) gives -0.
REQ-021 Class INF SHALL produce 64'h7FF0_0000_0000_0000.
REQ-022 Classes NAN and NEG_INVALID SHALL produce the canonical quiet NaN 64'h7FF8_0000_0000_0000.
REQ-023 Stall: when out_valid && !out_ready, out_data SHALL be held stable. Stage 1 SHALL advance only if stage 2 is empty or draining.
REQ-024 in_ready SHALL be asserted when stage 1 is empty or stage 1 advances this cycle. There is no combinational path from in_valid to in_ready.
REQ-025 Results SHALL leave in acceptance order with no loss or duplication. At most 2 results are in flight.
REQ-026 A simultaneous accept into stage 1 and drain of stage 2 in the same cycle SHALL sustain full throughput.

Reset
REQ-027 While rst_n is low, out_valid SHALL be 0, in_ready SHALL be 0, out_data SHALL be 64'h0, and both stage-valid flags SHALL be cleared, regardless of clk.
REQ-028 Asserting reset mid-operation SHALL discard in-flight results.
REQ-029 in_ready SHALL go to 1 on the first clock edge after rst_n deasserts.

Configuration
REQ-030 Macro DP_SQRT_FLAGS_EN defined: add output out_flags[1:0] = {invalid, inexact}, registered alongside out_data and reset to 2'b00.
- invalid = class NEG_INVALID.
- inexact = NORMAL && (in_root[0] || in_sticky).
REQ-031 Macro DP_SQRT_FLAGS_EN undefined: the out_flags port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 Package dp_sqrt_pkg SHALL hold:
- the class enum;
- constants QNAN64, PINF64, EXP_W=11, FRAC_W=52, ROOT_W=54.
REQ-033 Combinational sub-module dp_round_rne SHALL take a 52-bit fraction, round bit and sticky bit, and return the rounded fraction plus carry-out.

Verification
REQ-034 NORMAL, in_root=54'h20_0000_0000_0000, sticky 0, exp 11'h3FF -> out_data 64'h3FF0_0000_0000_0000 exactly 2 cycles later.
REQ-035 Tie to even, exp 11'h3FF, sticky 0:
- in_root=54'h20_0000_0000_0003 -> 64'h3FF0_0000_0000_0002.
- in_root=54'h20_0000_0000_0001 -> 64'h3FF0_0000_0000_0000.
REQ-036 Carry-out, in_root=54'h3F_FFFF_FFFF_FFFF, sticky 1, exp 11'h3FF -> 64'h4000_0000_0000_0000.
REQ-037 Special classes:
- NEG_INVALID -> 64'h7FF8_0000_0000_0000, flags 2'b10.
- ZERO with sign 1 -> 64'h8000_0000_0000_0000.
- INF -> 64'h7FF0_0000_0000_0000.
REQ-038 Backpressure: out_ready low for 5 cycles while 3 inputs are offered.
- in_ready drops after 2 accepts.
- out_data stays stable.
- After release, results emerge in order on consecutive cycles.
REQ-039 Reset with 2 results in flight -> out_valid 0 immediately; no stale result appears after reset release.
